tdm_demux_rx: RTL and testbench
===============================

# tdm_demux_rx

Frame-synchronised time-division demultiplexer: the receiving end of a serial TDM stream built by our 2:1-style multiplexers. It accepts one slot per `in_valid` strobe, tracks slot position against a frame marker and distributes slots into `CH_NUM` registered output channels. A completed frame is published atomically with a one-cycle `out_valid` pulse. The block sits between a serialised source (switch/key stimulus or an upstream mux chain) and the LED/channel consumers.

## Interface
- `CH_NUM`, 8, data slots per frame; legal range 2..16.
- `DATA_W`, 1, width of each slot in bits.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `in_valid`  in  1  slot strobe; one slot is consumed per cycle in which it is high.
- `in_data`  in  DATA_W  slot payload, sampled when `in_valid`=1.
- `in_sync`  in  1  frame marker, meaningful only with `in_valid`; 1 marks slot 0.
- `out_data`  out  CH_NUM*DATA_W  last good frame; channel k is at bits [k*DATA_W +: DATA_W].
- `out_valid`  out  1  one-cycle pulse when `out_data` has just been updated.
- `out_sel`  out  $clog2(CH_NUM+1)  index of the next expected slot.
- `locked`  out  1  high in the LOCK state.
- `sync_err`  out  1  one-cycle pulse on a framing violation.
- `parity_err`  out  1  one-cycle pulse on a parity failure; constant 0 without the feature.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `out_sel`=0, `locked`=0, `sync_err`=0, `parity_err`=0, state=HUNT, shadow register=0.
- HUNT: slots are discarded. On `in_valid`&`in_sync`, the slot is stored as channel 0, `out_sel`←1, state→LOCK.
- LOCK: on each `in_valid`, the slot is written into shadow channel `out_sel`, then `out_sel` increments. It wraps to 0 after the last slot of the frame: index CH_NUM-1, or CH_NUM with parity enabled.
- Sync mid-frame: `in_valid`&`in_sync` while `out_sel`≠0 gives a `sync_err` pulse. The partial frame is dropped. The slot is taken as channel 0 and `out_sel`←1. State stays LOCK.
- Missing sync: `in_valid`&!`in_sync` while `out_sel`=0 gives a `sync_err` pulse. The slot is discarded, state→HUNT and `out_sel`←0.
- Frame completion: when the last data slot is accepted, `out_data` is loaded with the shadow contents plus that slot, all in one edge. `out_valid` pulses in the same registered update. Channels never update individually.
- `in_valid`=0 cycles stall the frame indefinitely. There is no timeout.
- `in_data` and `in_sync` are ignored when `in_valid`=0.

## Timing
- Latency: the final slot is sampled at edge N, and `out_data`/`out_valid` are visible after edge N. This is one cycle of registered latency from input.
- Back-to-back frames at `in_valid`=1 every cycle produce `out_valid` once every CH_NUM cycles, or CH_NUM+1 with parity. There are no dead cycles between frames.
- `sync_err` and `parity_err` are registered and are high for exactly one cycle, following the offending slot's edge.
- If `rst_n` is asserted mid-frame, all state clears immediately. The partial frame is lost and `out_data` returns to 0.
- If `rst_n` is released in the same cycle as a sync slot, that slot is ignored. Capture begins on the next strobe.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - Each frame carries one extra trailing slot holding even parity: the XOR of all CH_NUM*DATA_W data bits, in `in_data[0]`, with the other bits ignored.
  - If parity matches, `out_data` updates and `out_valid` pulses on the parity slot.
  - If parity fails, `out_data` holds its previous value, `out_valid` stays 0, `parity_err` pulses and the state remains LOCK.
- `TDM_DEMUX_PARITY_EN` undefined:
  - Frames are CH_NUM slots long.
  - `parity_err` is tied to 0.
  - There is no parity logic.

## Test plan
- Reset then lock (CH_NUM=4, DATA_W=1, no parity): send slots 1,0,1,1 with sync on the first slot, strobing every cycle. `out_data` must become 4'b1101 and `out_valid` must pulse once, one cycle after the fourth slot. `locked` must be 1.
- Stalls: the same frame with `in_valid` gaps of 3 cycles between slots must give an identical `out_data` and a single `out_valid` pulse.
- Early sync: after 2 slots of a frame, send a sync slot. `sync_err` must pulse once, `out_data` must be unchanged and a new full frame 0,1,1,0 must then give 4'b0110.
- Missing sync: a complete frame followed by a slot with `in_sync`=0. `sync_err` must pulse, `locked` must drop to 0 and slots must be ignored until the next sync.
- Async reset mid-frame: assert `rst_n`=0 after slot 2 and hold it for less than one clock. All outputs must read 0 immediately, and `out_sel` must be 0 after release.
- Parity (`TDM_DEMUX_PARITY_EN`, CH_NUM=4): send frame 1,1,0,1 with parity slot 1. `out_valid` must pulse and `out_data` must be 4'b1011. Then send 1,1,0,1 with parity slot 0. `parity_err` must pulse and `out_data` must stay 4'b1011.

Source files
------------

// File: rtl/tdm_demux_rx.sv
// Frame-synchronised TDM demultiplexer: slots in, CH_NUM registered channels out.
// Optional trailing even-parity slot enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_rx #(
    parameter int CH_NUM = 8,
    parameter int DATA_W = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_sync,
    output logic [CH_NUM*DATA_W-1:0]     out_data,
    output logic                         out_valid,
    output logic [$clog2(CH_NUM+1)-1:0]  out_sel,
    output logic                         locked,
    output logic                         sync_err,
    output logic                         parity_err
);
    localparam int SEL_W = $clog2(CH_NUM+1);
`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CH_NUM);
`else
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CH_NUM - 1);
`endif

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                          state;
    logic                            armed;
    logic [CH_NUM-1:0][DATA_W-1:0]   shadow;
    logic [CH_NUM-1:0][DATA_W-1:0]   shadow_nxt;

    // Shadow with the current slot merged in; unchanged when out_sel points at the parity slot.
    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < CH_NUM; k++)
            if (out_sel == SEL_W'(k)) shadow_nxt[k] = in_data;
    end

    assign locked = (state == LOCK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            armed      <= 1'b0;
            shadow     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sel    <= '0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // armed keeps the first edge after reset release from capturing a slot
            armed      <= 1'b1;
            out_valid  <= 1'b0;
            sync_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (in_valid && armed) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            shadow[0] <= in_data;
                            out_sel   <= SEL_W'(1);
                            state     <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (in_sync) begin
                            if (out_sel != '0) sync_err <= 1'b1;
                            shadow[0] <= in_data;
                            out_sel   <= SEL_W'(1);
                        end else if (out_sel == '0) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end else if (out_sel == LAST) begin
                            out_sel <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                            if ((^shadow) == in_data[0]) begin
                                out_data  <= shadow_nxt;
                                out_valid <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
`else
                            out_data  <= shadow_nxt;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            shadow  <= shadow_nxt;
                            out_sel <= out_sel + SEL_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifndef TDM_DEMUX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx at CH_NUM=4, DATA_W=1; frames carry a parity
// slot when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_rx;
    localparam int CH_NUM = 4;
    localparam int DATA_W = 1;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sync;
    logic [CH_NUM*DATA_W-1:0] out_data;
    logic              out_valid;
    logic [2:0]        out_sel;
    logic              locked;
    logic              sync_err;
    logic              parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    tdm_demux_rx #(.CH_NUM(CH_NUM), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .out_data(out_data), .out_valid(out_valid),
        .out_sel(out_sel), .locked(locked), .sync_err(sync_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slot(input logic d, input logic s);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sync = s;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sync = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(posedge clk); #1;
            chk(tag, out_valid, 1'b0);
        end
    endtask

    // Sends a full frame b[0..3] (sync on slot 0), plus parity slot p when enabled.
    task automatic send_frame(input string tag, input logic [3:0] b, input logic p,
                              input int gap, input logic [3:0] exp_data, input logic exp_ok);
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && gap > 0) idle(gap, {tag, "_gap"});
            slot(b[i], i == 0);
            chk({tag, "_sync_err"}, sync_err, 1'b0);
            if (i < 3 || PAR) chk({tag, "_early_valid"}, out_valid, 1'b0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        if (gap > 0) idle(gap, {tag, "_gap"});
        slot(p, 1'b0);
`endif
        chk({tag, "_valid"}, out_valid, exp_ok);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_perr"}, parity_err, !exp_ok);
        chk({tag, "_sel"}, out_sel, 3'd0);
        chk({tag, "_locked"}, locked, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", out_data, 4'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sel", out_sel, 3'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);

        // sync slot presented in the release cycle must be ignored
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_sync = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sync = 1'b0;
        chk("release_locked", locked, 1'b0);
        chk("release_sel", out_sel, 3'd0);

        send_frame("lock", 4'b1101, 1'b1, 0, 4'b1101, 1'b1);
        idle(1, "lock_pulse_end");

        send_frame("stall", 4'b1101, 1'b1, 3, 4'b1101, 1'b1);
        idle(1, "stall_pulse_end");

        // early sync: two slots, then a sync slot restarts the frame
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0);
        chk("early_sel2", out_sel, 3'd2);
        slot(1'b0, 1'b1);
        chk("early_sync_err", sync_err, 1'b1);
        chk("early_sel", out_sel, 3'd1);
        chk("early_data_hold", out_data, 4'b1101);
        chk("early_locked", locked, 1'b1);
        slot(1'b1, 1'b0);
        chk("early_err_clear", sync_err, 1'b0);
        slot(1'b1, 1'b0);
        slot(1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        slot(1'b0, 1'b0);
`endif
        chk("early_new_valid", out_valid, 1'b1);
        chk("early_new_data", out_data, 4'b0110);

        // missing sync after a complete frame drops lock
        slot(1'b1, 1'b0);
        chk("miss_sync_err", sync_err, 1'b1);
        chk("miss_locked", locked, 1'b0);
        chk("miss_sel", out_sel, 3'd0);
        for (int i = 0; i < 5; i++) begin
            slot(1'b1, 1'b0);
            chk("hunt_locked", locked, 1'b0);
            chk("hunt_valid", out_valid, 1'b0);
            chk("hunt_sel", out_sel, 3'd0);
            chk("hunt_sync_err", sync_err, 1'b0);
        end
        chk("hunt_data_hold", out_data, 4'b0110);
        send_frame("relock", 4'b1111, 1'b0, 0, 4'b1111, 1'b1);

        // async reset mid-frame, shorter than one clock
        slot(1'b1, 1'b1);
        slot(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", out_data, 4'h0);
        chk("arst_sel", out_sel, 3'd0);
        chk("arst_locked", locked, 1'b0);
        chk("arst_valid", out_valid, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_sel", out_sel, 3'd0);
        chk("arst_rel_locked", locked, 1'b0);
        send_frame("post_rst", 4'b1100, 1'b0, 0, 4'b1100, 1'b1);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame("par_ok", 4'b1011, 1'b1, 0, 4'b1011, 1'b1);
        send_frame("par_bad", 4'b1011, 1'b0, 0, 4'b1011, 1'b0);
        idle(1, "par_pulse_end");
        chk("par_err_clear", parity_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
